// File: rtl/apb_slv_regbank.sv
// apb_slv_regbank
//   APB completer that exposes a word-addressed bank of NUM_REGS registers.
//   Register writes honour the byte strobes. Registers flagged in RO_MASK are
//   read-only and return their status_in slice. Every access phase is
//   stretched by WAIT_STATES cycles. PSLVERR is raised for an out-of-range
//   index, an unaligned address or a write to a read-only register.
//
// Ports
//   pclk, preset           clock, synchronous active-high reset
//   psel, penable, paddr,
//   pwrite, pwdata, pstrb  APB request
//   prdata, pready,
//   pslverr                APB response; all three are forced to 0 during reset
//   reg_q                  R/W register contents, register i at [i*32 +: 32]
//   status_in              read-only sources, slice i at [i*32 +: 32]
module apb_slv_regbank #(
  parameter int unsigned           ADDR_WIDTH  = 12,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 8,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   bank_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   bank_d [NUM_REGS];

  // Decode of the live address, used only at setup
  logic                    hit;
  logic                    ro;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    bank_d  = bank_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    hit     = 1'b0;
    ro      = 1'b0;

    // Index match by loop keeps the range check free of width-mismatched
    // compares against NUM_REGS.
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (paddr[ADDR_WIDTH-1:2] == IDX_W'(i)) begin
        hit = 1'b1;
        ro  = RO_MASK[i];
      end
    end

    if (!preset) begin
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            idx_d   = paddr[ADDR_WIDTH-1:2];
            write_d = pwrite;
            err_d   = !hit || (paddr[1:0] != 2'b00) || (pwrite && ro);
            cnt_d   = 4'(WAIT_STATES);
            state_d = ACCESS;
          end else if (psel && penable) begin
            // Access phase without a setup: fail it immediately
            pready  = 1'b1;
            pslverr = 1'b1;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_d = IDLE;
          end else if (penable) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 4'd1;
            end else begin
              pready  = 1'b1;
              state_d = IDLE;
              if (err_q) begin
                pslverr = 1'b1;
              end else begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                    if (write_q) begin
                      for (int unsigned k = 0; k < NB; k++) begin
                        if (pstrb[k]) bank_d[i][k*8 +: 8] = pwdata[k*8 +: 8];
                      end
                    end else begin
                      prdata = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH]
                                          : bank_q[i];
                    end
                  end
                end
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) bank_q[i] <= RESET_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = bank_q[i];
  end

endmodule

// File: tb/tb_apb_slv_regbank.sv
// Directed bench for apb_slv_regbank: one instance with no wait states and
// one with three, sharing the bus except for psel.
module tb_apb_slv_regbank;

  logic         pclk = 1'b0;
  logic         preset;
  logic         psel, penable, pwrite;
  logic [11:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic         sel_dut;
  logic [255:0] status_in;

  logic [31:0]  prdata0, prdata3, prdata;
  logic         pready0, pready3, pready;
  logic         pslverr0, pslverr3, pslverr;
  logic [255:0] reg_q0, reg_q3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_slv_regbank #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(0),
    .RO_MASK(8'h04), .RESET_VAL(32'h0)
  ) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel && !sel_dut), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .reg_q(reg_q0), .status_in(status_in)
  );

  apb_slv_regbank #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(3),
    .RO_MASK(8'h04), .RESET_VAL(32'h0)
  ) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel && sel_dut), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
    .reg_q(reg_q3), .status_in(status_in)
  );

  assign prdata  = sel_dut ? prdata3  : prdata0;
  assign pready  = sel_dut ? pready3  : pready0;
  assign pslverr = sel_dut ? pslverr3 : pslverr0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a clock edge; returns just after the completing edge
  // with psel/penable still high so a back-to-back setup may follow.
  task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic err,
                      output int waits);
    logic done;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0; rd = '0; err = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge pclk);
      if (pready) begin
        rd = prdata; err = pslverr; done = 1'b1;
      end else begin
        waits++;
        if (waits > 40) begin
          check("timeout", 32'd1, 32'd0);
          done = 1'b1;
        end
        @(posedge pclk); #1;
      end
    end
    @(posedge pclk); #1;
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  logic [31:0] rd;
  logic        err;
  int          w;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel_dut = 1'b0;
    for (int i = 0; i < 8; i++) status_in[i*32 +: 32] = 32'hA5A50000 | 32'(i);

    // Reset: outputs forced low even with a protocol-violating bus
    repeat (2) @(posedge pclk);
    #1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h004; pwdata = '1; pstrb = '1;
    @(negedge pclk);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; preset = 1'b0;
    check("rst_reg1", reg_q0[63:32], 32'd0);

    // Zero-wait write/read
    xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, rd, err, w);
    check("wr1_err", 32'(err), 32'd0);
    check("wr1_wait", w, 32'd0);
    xfer(1'b0, 12'h004, 32'h0, 4'h0, rd, err, w);
    check("rd1_data", rd, 32'hDEADBEEF);
    check("rd1_err", 32'(err), 32'd0);
    check("rd1_wait", w, 32'd0);
    idle();
    check("reg1_out", reg_q0[63:32], 32'hDEADBEEF);

    // Byte strobe
    xfer(1'b1, 12'h004, 32'h0000AB00, 4'b0010, rd, err, w);
    xfer(1'b0, 12'h004, 32'h0, 4'hF, rd, err, w);
    check("strb_data", rd, 32'hDEADABEF);
    idle();

    // Error cases
    xfer(1'b0, 12'h020, 32'h0, 4'hF, rd, err, w);
    check("oor_err", 32'(err), 32'd1);
    check("oor_data", rd, 32'd0);
    xfer(1'b0, 12'h006, 32'h0, 4'hF, rd, err, w);
    check("unal_err", 32'(err), 32'd1);
    check("unal_data", rd, 32'd0);
    xfer(1'b1, 12'h008, 32'hFFFFFFFF, 4'hF, rd, err, w);
    check("ro_wr_err", 32'(err), 32'd1);
    xfer(1'b0, 12'h008, 32'h0, 4'hF, rd, err, w);
    check("ro_rd_data", rd, 32'hA5A50002);
    check("ro_rd_err", 32'(err), 32'd0);
    idle();
    check("ro_reg_keep", reg_q0[95:64], 32'd0);

    // Three wait states, then an abort after two waits
    sel_dut = 1'b1;
    xfer(1'b1, 12'h00C, 32'h5555AAAA, 4'hF, rd, err, w);
    check("ws_wr_wait", w, 32'd3);
    check("ws_wr_err", 32'(err), 32'd0);
    xfer(1'b0, 12'h00C, 32'h0, 4'hF, rd, err, w);
    check("ws_rd_wait", w, 32'd3);
    check("ws_rd_data", rd, 32'h5555AAAA);
    idle();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      check("abort_wait", 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
    idle();
    xfer(1'b0, 12'h00C, 32'h0, 4'hF, rd, err, w);
    check("abort_data", rd, 32'h5555AAAA);
    check("abort_wait_rd", w, 32'd3);
    idle();

    // Access phase without setup
    sel_dut = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    check("noset_pready", 32'(pready), 32'd1);
    check("noset_pslverr", 32'(pslverr), 32'd1);
    @(posedge pclk); #1;
    idle();
    check("noset_reg1", reg_q0[63:32], 32'hDEADABEF);
    xfer(1'b0, 12'h004, 32'h0, 4'hF, rd, err, w);
    check("noset_rd", rd, 32'hDEADABEF);
    check("noset_rd_wait", w, 32'd0);
    idle();

    // Reset in the middle of an access
    sel_dut = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(negedge pclk);
    check("mid_rst_pready", 32'(pready), 32'd0);
    check("mid_rst_pslverr", 32'(pslverr), 32'd0);
    check("mid_rst_prdata", prdata, 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    check("mid_rst_reg1", reg_q3[63:32], 32'd0);
    check("mid_rst_reg3", reg_q3[127:96], 32'd0);
    check("mid_rst_dut0", reg_q0[63:32], 32'd0);
    xfer(1'b0, 12'h004, 32'h0, 4'hF, rd, err, w);
    check("post_rst_rd", rd, 32'd0);
    check("post_rst_wait", w, 32'd3);
    idle();

    // Back-to-back write then read
    sel_dut = 1'b0;
    xfer(1'b1, 12'h000, 32'h00000011, 4'hF, rd, err, w);
    xfer(1'b0, 12'h000, 32'h0, 4'hF, rd, err, w);
    check("b2b_data", rd, 32'h00000011);
    check("b2b_wait", w, 32'd0);
    idle();
    check("b2b_reg0", reg_q0[31:0], 32'h00000011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
